// File: rtl/multi_pulse_gen_pkg.sv
// Shared types and elaboration helpers for the multi-channel tick generator.
package multi_pulse_gen_pkg;

   typedef enum logic {
      MODE_PERIODIC = 1'b0,
      MODE_ONESHOT  = 1'b1
   } mode_e;

   localparam int unsigned MAX_CH = 16;

   // Divisor that yields a tick rate of hz from a clk_hz system clock.
   function automatic int unsigned hz_to_div(int unsigned clk_hz, int unsigned hz);
      return (hz == 0) ? 0 : clk_hz / hz;
   endfunction

   // Narrowest counter that can still hold max_div.
   function automatic int unsigned min_cnt_w(int unsigned max_div);
      return (max_div < 2) ? 1 : $clog2(max_div + 1);
   endfunction

endpackage

// File: rtl/pulse_chan.sv
// One tick channel: active/shadow divisor and mode, pending flag, counter, one-shot busy.
module pulse_chan
   import multi_pulse_gen_pkg::*;
#(
   parameter int unsigned CNT_W   = 26,
   parameter int unsigned DEF_DIV = 25_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync_clr,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_div,
   input  mode_e            cfg_mode,
   input  logic             arm,
   output logic             tick,
   output logic             busy,
   output logic             pending
);

   localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] sh_div_q, sh_div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mode_e            mode_q, mode_d;
   mode_e            sh_mode_q, sh_mode_d;
   logic             pend_q, pend_d;
   logic             busy_q, busy_d;
   logic             tick_q, tick_d;

   logic [CNT_W-1:0] last_cnt;
   logic             running;
   logic             wrap;
   logic             arm_ok;

   // D of 0 and 1 both collapse to a wrap on every enabled cycle.
   always_comb begin
      last_cnt = (div_q[CNT_W-1:1] == '0) ? '0 : div_q - 1'b1;
      running  = (mode_q == MODE_PERIODIC) || busy_q;
      wrap     = en && running && (cnt_q == last_cnt);
      arm_ok   = arm && (mode_q == MODE_ONESHOT) && !(cfg_we && !running);
   end

   always_comb begin
      div_d     = div_q;
      mode_d    = mode_q;
      sh_div_d  = sh_div_q;
      sh_mode_d = sh_mode_q;
      pend_d    = pend_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      tick_d    = 1'b0;

      if (sync_clr) begin
         cnt_d  = '0;
         busy_d = 1'b0;
         if (pend_q) begin
            div_d  = sh_div_q;
            mode_d = sh_mode_q;
            pend_d = 1'b0;
         end
         if (cfg_we) begin
            div_d  = cfg_div;
            mode_d = cfg_mode;
         end
      end else begin
         if (cfg_we) begin
            if (!running) begin
               div_d  = cfg_div;
               mode_d = cfg_mode;
               cnt_d  = '0;
            end else begin
               sh_div_d  = cfg_div;
               sh_mode_d = cfg_mode;
               pend_d    = 1'b1;
            end
         end

         // A pending apply on the wrap edge outranks a same-cycle arm; a plain wrap does not.
         if (wrap && pend_q) begin
            tick_d = 1'b1;
            cnt_d  = '0;
            busy_d = 1'b0;
            div_d  = sh_div_q;
            mode_d = sh_mode_q;
            pend_d = 1'b0;
         end else if (arm_ok) begin
            cnt_d  = '0;
            busy_d = 1'b1;
         end else if (wrap) begin
            tick_d = 1'b1;
            cnt_d  = '0;
            busy_d = 1'b0;
         end else if (en && running) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q     <= RST_DIV;
         mode_q    <= MODE_PERIODIC;
         sh_div_q  <= RST_DIV;
         sh_mode_q <= MODE_PERIODIC;
         pend_q    <= 1'b0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         div_q     <= div_d;
         mode_q    <= mode_d;
         sh_div_q  <= sh_div_d;
         sh_mode_q <= sh_mode_d;
         pend_q    <= pend_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         tick_q    <= tick_d;
      end
   end

   assign tick    = tick_q;
   assign busy    = busy_q;
   assign pending = pend_q;

endmodule

// File: rtl/multi_pulse_gen.sv
// Multi-channel tick generator: configuration decode, cfg_ready mux and NUM_CH channels.
module multi_pulse_gen
   import multi_pulse_gen_pkg::*;
#(
   parameter  int unsigned CLK_HZ  = 50_000_000,
   parameter  int unsigned NUM_CH  = 4,
   parameter  int unsigned CNT_W   = 26,
   parameter  int unsigned DEF_DIV = hz_to_div(CLK_HZ, 2),
   localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              sync_clr,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_mode,
   input  logic [NUM_CH-1:0] arm,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] busy
);

   if ((NUM_CH < 1) || (NUM_CH > MAX_CH)) begin : g_bad_num_ch
      $error("multi_pulse_gen: NUM_CH must be within 1..16");
   end
   if ((CNT_W < 2) || (CNT_W < min_cnt_w(DEF_DIV))) begin : g_bad_cnt_w
      $error("multi_pulse_gen: CNT_W too narrow for DEF_DIV");
   end
   if (hz_to_div(CLK_HZ, 1) == 0) begin : g_bad_clk_hz
      $error("multi_pulse_gen: CLK_HZ must be non-zero");
   end

   logic [NUM_CH-1:0] pend;
   logic              ch_ok;
   logic              accept;

   // Out-of-range channel numbers are accepted and dropped so they cannot stall the bus.
   assign ch_ok     = {1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH);
   assign cfg_ready = ch_ok ? ~pend[cfg_ch] : 1'b1;
   assign accept    = cfg_valid && cfg_ready && ch_ok;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pulse_chan #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .sync_clr (sync_clr),
         .cfg_we   (accept && (cfg_ch == CH_W'(i))),
         .cfg_div  (cfg_div),
         .cfg_mode (mode_e'(cfg_mode)),
         .arm      (arm[i]),
         .tick     (tick[i]),
         .busy     (busy[i]),
         .pending  (pend[i])
      );
   end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Directed bench for multi_pulse_gen with DEF_DIV = 5, four channels, 8-bit counters.
module tb_multi_pulse_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       sync_clr;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_div;
   logic       cfg_mode;
   logic [3:0] arm;
   logic [3:0] tick;
   logic [3:0] busy;

   int n_checks = 0;
   int n_fail   = 0;

   multi_pulse_gen #(
      .CLK_HZ  (1000),
      .NUM_CH  (4),
      .CNT_W   (8),
      .DEF_DIV (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .sync_clr  (sync_clr),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_mode  (cfg_mode),
      .arm       (arm),
      .tick      (tick),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Leaves the bench at "edge 0": 1 ns after an edge, reset released, en high.
   task automatic reset_dut();
      rst = 1'b1; en = 1'b0; sync_clr = 1'b0; cfg_valid = 1'b0;
      cfg_ch = 2'd0; cfg_div = 8'd0; cfg_mode = 1'b0; arm = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      en  = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; sync_clr = 1'b0; cfg_valid = 1'b0;
      cfg_ch = 2'd0; cfg_div = 8'd0; cfg_mode = 1'b0; arm = 4'b0000;
      @(posedge clk); #1;
      n_checks++;
      if (tick !== 4'b0000) begin n_fail++; $display("FAIL reset_tick got=%b exp=0000", tick); end
      n_checks++;
      if (busy !== 4'b0000) begin n_fail++; $display("FAIL reset_busy got=%b exp=0000", busy); end
      n_checks++;
      if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
      rst = 1'b0;
      en  = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         logic [3:0] exp_t;
         @(posedge clk); #1;
         exp_t = (k % 5 == 0) ? 4'b1111 : 4'b0000;
         n_checks++;
         if (tick !== exp_t) begin n_fail++; $display("FAIL default_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
      end
   endtask

   task automatic test_reconfig();
      reset_dut();
      for (int k = 1; k <= 13; k++) begin
         logic [3:0] exp_t;
         logic       exp_r;
         @(posedge clk); #1;
         exp_t = 4'b0000;
         if (k == 5 || k == 10) exp_t = exp_t | 4'b1101;
         if (k == 5 || k == 8 || k == 12) exp_t[1] = 1'b1;
         exp_r = !(k == 3 || k == 4 || k == 6 || k == 7);
         n_checks++;
         if (tick !== exp_t) begin n_fail++; $display("FAIL reconfig_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
         n_checks++;
         if (cfg_ready !== exp_r) begin n_fail++; $display("FAIL reconfig_ready k=%0d got=%b exp=%b", k, cfg_ready, exp_r); end
         if (k == 2) begin cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3; cfg_mode = 1'b0; end
         if (k == 3) cfg_div = 8'd4;
         if (k == 6) cfg_valid = 1'b0;
      end
   endtask

   task automatic test_oneshot();
      reset_dut();
      cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd4; cfg_mode = 1'b1;
      for (int k = 1; k <= 28; k++) begin
         logic [3:0] exp_t;
         logic       exp_b;
         logic       exp_r;
         @(posedge clk); #1;
         exp_t = (k % 5 == 0) ? 4'b1011 : 4'b0000;
         if (k == 5 || k == 14 || k == 26) exp_t[2] = 1'b1;
         exp_b = (k >= 10 && k <= 13) || (k >= 20 && k <= 25);
         exp_r = !(k >= 1 && k <= 4);
         n_checks++;
         if (tick !== exp_t) begin n_fail++; $display("FAIL oneshot_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
         n_checks++;
         if (busy !== {1'b0, exp_b, 2'b00}) begin n_fail++; $display("FAIL oneshot_busy k=%0d got=%b exp=%b", k, busy, {1'b0, exp_b, 2'b00}); end
         n_checks++;
         if (cfg_ready !== exp_r) begin n_fail++; $display("FAIL oneshot_ready k=%0d got=%b exp=%b", k, cfg_ready, exp_r); end
         if (k == 1) cfg_valid = 1'b0;
         if (k == 9 || k == 19 || k == 21) arm = 4'b0100;
         if (k == 10 || k == 20 || k == 22) arm = 4'b0000;
      end
   endtask

   task automatic test_en_pause();
      reset_dut();
      for (int k = 1; k <= 14; k++) begin
         logic [3:0] exp_t;
         @(posedge clk); #1;
         exp_t = (k == 8 || k == 13) ? 4'b1111 : 4'b0000;
         n_checks++;
         if (tick !== exp_t) begin n_fail++; $display("FAIL en_pause_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
         if (k == 2) en = 1'b0;
         if (k == 5) en = 1'b1;
      end
   endtask

   task automatic test_sync_clr();
      reset_dut();
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd7; cfg_mode = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         logic [3:0] exp_t;
         logic       exp_r;
         @(posedge clk); #1;
         exp_t    = 4'b0000;
         exp_t[0] = (k == 10 || k == 17);
         exp_t[1] = (k >= 5) && (k % 2 == 1);
         exp_t[2] = (k == 8 || k == 13 || k == 18);
         exp_t[3] = exp_t[2];
         exp_r    = (k >= 3);
         n_checks++;
         if (tick !== exp_t) begin n_fail++; $display("FAIL sync_clr_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
         n_checks++;
         if (cfg_ready !== exp_r) begin n_fail++; $display("FAIL sync_clr_ready k=%0d got=%b exp=%b", k, cfg_ready, exp_r); end
         if (k == 1) cfg_valid = 1'b0;
         if (k == 2) begin sync_clr = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd2; end
         if (k == 3) begin sync_clr = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; end
      end
   endtask

   task automatic test_d01_and_rst();
      reset_dut();
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0; cfg_mode = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         logic [3:0] exp_t;
         @(posedge clk); #1;
         exp_t = 4'b0000;
         if (k >= 4) exp_t = 4'b0011;
         if (k == 8) exp_t = 4'b1111;
         n_checks++;
         if (tick !== exp_t) begin n_fail++; $display("FAIL d01_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
         n_checks++;
         if (busy !== 4'b0000) begin n_fail++; $display("FAIL d01_busy k=%0d got=%b exp=0000", k, busy); end
         if (k == 1) begin cfg_ch = 2'd1; cfg_div = 8'd1; end
         if (k == 2) begin cfg_valid = 1'b0; sync_clr = 1'b1; end
         if (k == 3) begin sync_clr = 1'b0; arm = 4'b1000; end
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (tick !== 4'b0000) begin n_fail++; $display("FAIL rst_async_tick got=%b exp=0000", tick); end
      n_checks++;
      if (busy !== 4'b0000) begin n_fail++; $display("FAIL rst_async_busy got=%b exp=0000", busy); end
      n_checks++;
      if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_ready got=%b exp=1", cfg_ready); end
      @(posedge clk); #1;
      n_checks++;
      if (tick !== 4'b0000) begin n_fail++; $display("FAIL rst_hold_tick got=%b exp=0000", tick); end
      rst = 1'b0;
      arm = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_reconfig();
      test_oneshot();
      test_en_pause();
      test_sync_clr();
      test_d01_and_rst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
